// File: rtl/rfb_column_sequencer_if.sv
// Bundle-in / beat-out signal group between the rotational frame buffer,
// the column sequencer and the HUB75 driver.
interface rfb_column_sequencer_if #(
   parameter int unsigned NUM_CHANNELS = 2,
   parameter int unsigned NUM_ROWS     = 64,
   parameter int unsigned SCAN_RATE    = 32,
   parameter int unsigned RGB_RES      = 9
);
   localparam int unsigned CW = $clog2(SCAN_RATE);
   localparam int unsigned IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   logic                                                 in_valid;
   logic                                                 in_ready;
   logic [NUM_CHANNELS-1:0][CW-1:0]                      radii_input;
   logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0]                rfb_cols_input;
   logic [NUM_CHANNELS-1:0][RGB_RES-1:0]                 colour_input;
   logic                                                 hub75_ready;
   logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0]   columns;
   logic [CW-1:0]                                        col_num;
   logic [IW-1:0]                                        chan_idx;
   logic                                                 data_valid;
   logic                                                 seq_done;

   // Environment side: frame buffer source plus HUB75 driver back-pressure.
   modport master (
      output in_valid, radii_input, rfb_cols_input, colour_input, hub75_ready,
      input  in_ready, columns, col_num, chan_idx, data_valid, seq_done
   );

   // Sequencer side.
   modport slave (
      input  in_valid, radii_input, rfb_cols_input, colour_input, hub75_ready,
      output in_ready, columns, col_num, chan_idx, data_valid, seq_done
   );
endinterface

// File: rtl/rfb_column_sequencer.sv
// Latches one bundle of per-channel columns and emits one expanded RGB
// column per beat to the HUB75 driver, in ascending channel order.
module rfb_column_sequencer #(
   parameter int unsigned NUM_CHANNELS = 2,
   parameter int unsigned NUM_ROWS     = 64,
   parameter int unsigned SCAN_RATE    = 32,
   parameter int unsigned RGB_RES      = 9,
   parameter int unsigned SKIP_EMPTY   = 0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   rfb_column_sequencer_if.slave bus
);
   localparam int unsigned CW = $clog2(SCAN_RATE);
   localparam int unsigned IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   typedef enum logic {IDLE, EMIT} state_t;
   typedef logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] pix_t;

   state_t                                 state;
   logic [NUM_CHANNELS-1:0][CW-1:0]        radii_q;
   logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0]  cols_q;
   logic [NUM_CHANNELS-1:0][RGB_RES-1:0]   colour_q;
   pix_t                                   columns_q;
   logic [CW-1:0]                          col_num_q;
   logic [IW-1:0]                          chan_q;
   logic                                   valid_q;
   logic                                   done_q;
   logic                                   in_ready;

   logic                                   first_found;
   logic [IW-1:0]                          first_idx;
   logic                                   next_found;
   logic [IW-1:0]                          next_idx;

   function automatic pix_t expand(input logic [IW-1:0]       k,
                                   input logic [NUM_ROWS-1:0] col,
                                   input logic [RGB_RES-1:0]  colour);
      pix_t p;
      p = '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++)
         p[k][r] = col[r] ? colour : '0;
      return p;
   endfunction

   assign in_ready = (state == IDLE);

   // First qualifying channel of the incoming bundle, and the next one above
   // the active channel within the latched bundle.
   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
         if (!first_found && (SKIP_EMPTY == 0 || |bus.rfb_cols_input[k])) begin
            first_found = 1'b1;
            first_idx   = IW'(k);
         end
         if (!next_found && IW'(k) > chan_q && (SKIP_EMPTY == 0 || |cols_q[k])) begin
            next_found = 1'b1;
            next_idx   = IW'(k);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= IDLE;
         radii_q   <= '0;
         cols_q    <= '0;
         colour_q  <= '0;
         columns_q <= '0;
         col_num_q <= '0;
         chan_q    <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready) begin
                  radii_q  <= bus.radii_input;
                  cols_q   <= bus.rfb_cols_input;
                  colour_q <= bus.colour_input;
                  if (first_found) begin
                     state     <= EMIT;
                     valid_q   <= 1'b1;
                     chan_q    <= first_idx;
                     col_num_q <= bus.radii_input[first_idx];
                     columns_q <= expand(first_idx, bus.rfb_cols_input[first_idx],
                                         bus.colour_input[first_idx]);
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (bus.hub75_ready) begin
                  if (next_found) begin
                     chan_q    <= next_idx;
                     col_num_q <= radii_q[next_idx];
                     columns_q <= expand(next_idx, cols_q[next_idx], colour_q[next_idx]);
                  end else begin
                     state     <= IDLE;
                     valid_q   <= 1'b0;
                     columns_q <= '0;
                     done_q    <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.columns    = columns_q;
   assign bus.col_num    = col_num_q;
   assign bus.chan_idx   = chan_q;
   assign bus.data_valid = valid_q;
   assign bus.seq_done   = done_q;

endmodule

// File: tb/tb_rfb_column_sequencer.sv
// Directed bench for two sequencer configurations: 2 channels without skip,
// 4 channels with empty-column skip; beats are checked against a scoreboard.
module tb_rfb_column_sequencer;

   typedef struct {
      int           chan;
      logic [4:0]   radius;
      logic [575:0] pix;
   } beat_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   beat_t      sb_a[$];
   beat_t      sb_b[$];
   beat_t      last_beat;
   logic [4:0] rad[4];
   logic [63:0] col[4];
   logic [8:0] clr[4];
   bit         any;

   rfb_column_sequencer_if #(.NUM_CHANNELS(2), .NUM_ROWS(64), .SCAN_RATE(32), .RGB_RES(9)) bus_a ();
   rfb_column_sequencer_if #(.NUM_CHANNELS(4), .NUM_ROWS(64), .SCAN_RATE(32), .RGB_RES(9)) bus_b ();

   rfb_column_sequencer #(
      .NUM_CHANNELS(2), .NUM_ROWS(64), .SCAN_RATE(32), .RGB_RES(9), .SKIP_EMPTY(0)
   ) dut_a (
      .clk_in(clk),
      .rst_in(rst_n),
      .bus(bus_a.slave)
   );

   rfb_column_sequencer #(
      .NUM_CHANNELS(4), .NUM_ROWS(64), .SCAN_RATE(32), .RGB_RES(9), .SKIP_EMPTY(1)
   ) dut_b (
      .clk_in(clk),
      .rst_in(rst_n),
      .bus(bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [575:0] model_pix(input logic [63:0] c, input logic [8:0] v);
      logic [575:0] p;
      p = '0;
      for (int r = 0; r < 64; r++)
         if (c[r]) p[r*9 +: 9] = v;
      return p;
   endfunction

   task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_bundle();
      for (int k = 0; k < 4; k++) begin
         rad[k] = 5'($urandom_range(0, 31));
         col[k] = {$urandom, $urandom};
         clr[k] = 9'($urandom_range(0, 511));
      end
   endtask

   // Present the bundle in rad/col/clr to DUT d and queue the beats it must produce.
   task automatic drive(input int d, output bit found);
      beat_t b;
      found = 1'b0;
      for (int k = 0; k < ((d == 1) ? 4 : 2); k++) begin
         if (d == 1) begin
            bus_b.radii_input[k[1:0]]    = rad[k];
            bus_b.rfb_cols_input[k[1:0]] = col[k];
            bus_b.colour_input[k[1:0]]   = clr[k];
         end else begin
            bus_a.radii_input[k[0]]    = rad[k];
            bus_a.rfb_cols_input[k[0]] = col[k];
            bus_a.colour_input[k[0]]   = clr[k];
         end
         if (d == 0 || col[k] != '0) begin
            b.chan   = k;
            b.radius = rad[k];
            b.pix    = model_pix(col[k], clr[k]);
            if (d == 1) sb_b.push_back(b);
            else        sb_a.push_back(b);
            found = 1'b1;
         end
      end
      if (d == 1) bus_b.in_valid = 1'b1;
      else        bus_a.in_valid = 1'b1;
   endtask

   task automatic cmp_beat(input int d, input string tag, input beat_t b);
      logic [575:0] c;
      chk({tag, ".valid"}, 576'((d == 1) ? bus_b.data_valid : bus_a.data_valid), 576'(1));
      chk({tag, ".done"},  576'((d == 1) ? bus_b.seq_done : bus_a.seq_done), 576'(0));
      chk({tag, ".ready"}, 576'((d == 1) ? bus_b.in_ready : bus_a.in_ready), 576'(0));
      chk({tag, ".chan"},  576'((d == 1) ? 32'(bus_b.chan_idx) : 32'(bus_a.chan_idx)), 576'(b.chan));
      chk({tag, ".colnum"}, 576'((d == 1) ? bus_b.col_num : bus_a.col_num), 576'(b.radius));
      for (int j = 0; j < ((d == 1) ? 4 : 2); j++) begin
         c = (d == 1) ? bus_b.columns[j[1:0]] : bus_a.columns[j[0]];
         chk($sformatf("%s.col%0d", tag, j), c, (j == b.chan) ? b.pix : '0);
      end
   endtask

   task automatic beat(input int d, input string tag);
      if (((d == 1) ? sb_b.size() : sb_a.size()) == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed beat request expected queued beat (scoreboard empty)", tag);
      end else begin
         last_beat = (d == 1) ? sb_b.pop_front() : sb_a.pop_front();
         cmp_beat(d, tag, last_beat);
      end
   endtask

   task automatic idle(input int d, input string tag, input bit done);
      logic [575:0] c;
      chk({tag, ".valid"}, 576'((d == 1) ? bus_b.data_valid : bus_a.data_valid), 576'(0));
      chk({tag, ".done"},  576'((d == 1) ? bus_b.seq_done : bus_a.seq_done), 576'(done));
      chk({tag, ".ready"}, 576'((d == 1) ? bus_b.in_ready : bus_a.in_ready), 576'(1));
      for (int j = 0; j < ((d == 1) ? 4 : 2); j++) begin
         c = (d == 1) ? bus_b.columns[j[1:0]] : bus_a.columns[j[0]];
         chk($sformatf("%s.col%0d", tag, j), c, '0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus_a.in_valid = 1'b0; bus_a.hub75_ready = 1'b1;
      bus_a.radii_input = '0; bus_a.rfb_cols_input = '0; bus_a.colour_input = '0;
      bus_b.in_valid = 1'b0; bus_b.hub75_ready = 1'b1;
      bus_b.radii_input = '0; bus_b.rfb_cols_input = '0; bus_b.colour_input = '0;

      // Reset state; a handshake during reset must not be honoured.
      tick();
      idle(0, "rst_a", 1'b0);
      idle(1, "rst_b", 1'b0);
      chk("rst_a.colnum", 576'(bus_a.col_num), 576'(0));
      chk("rst_a.chan", 576'(bus_a.chan_idx), 576'(0));
      bus_a.in_valid = 1'b1;
      bus_a.rfb_cols_input = '1;
      tick();
      tick();
      idle(0, "rst_hs", 1'b0);
      bus_a.in_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      // Basic two-channel sequence with continuous ready.
      rad = '{5'd5, 5'd17, 5'd0, 5'd0};
      col = '{64'h1, 64'h8000_0000_0000_0000, 64'h0, 64'h0};
      clr = '{9'h1FF, 9'h0AA, 9'h0, 9'h0};
      drive(0, any);
      tick();
      bus_a.in_valid = 1'b0;
      beat(0, "t1.b0");
      tick();
      beat(0, "t1.b1");
      tick();
      idle(0, "t1.done", 1'b1);
      tick();
      idle(0, "t1.post", 1'b0);

      // Stall on beat 0: outputs frozen, changed inputs ignored.
      bus_a.hub75_ready = 1'b0;
      drive(0, any);
      tick();
      beat(0, "t2.b0");
      bus_a.radii_input = '1;
      bus_a.rfb_cols_input = '1;
      bus_a.colour_input = '1;
      for (int i = 0; i < 4; i++) begin
         tick();
         cmp_beat(0, $sformatf("t2.hold%0d", i), last_beat);
      end
      bus_a.in_valid = 1'b0;
      bus_a.hub75_ready = 1'b1;
      tick();
      beat(0, "t2.b1");
      tick();
      idle(0, "t2.done", 1'b1);
      tick();

      // Skip-empty: single non-empty channel 2.
      rad = '{5'd1, 5'd2, 5'd9, 5'd4};
      col = '{64'h0, 64'h0, 64'hF0F0_0000_0000_0301, 64'h0};
      clr = '{9'h011, 9'h022, 9'h155, 9'h044};
      drive(1, any);
      tick();
      bus_b.in_valid = 1'b0;
      beat(1, "t3.b2");
      tick();
      idle(1, "t3.done", 1'b1);
      tick();
      idle(1, "t3.post", 1'b0);

      // Skip-empty: all-zero bundle completes with no beat.
      col = '{64'h0, 64'h0, 64'h0, 64'h0};
      drive(1, any);
      chk("t3.model_empty", 576'(any), 576'(0));
      tick();
      bus_b.in_valid = 1'b0;
      idle(1, "t3.empty", 1'b1);
      tick();
      idle(1, "t3.empty_post", 1'b0);

      // Skip-empty: channels 1 and 3 only.
      rand_bundle();
      col[0] = '0;
      col[2] = '0;
      col[1][7] = 1'b1;
      col[3][60] = 1'b1;
      drive(1, any);
      tick();
      bus_b.in_valid = 1'b0;
      beat(1, "t3s.b1");
      tick();
      beat(1, "t3s.b3");
      tick();
      idle(1, "t3s.done", 1'b1);
      tick();

      // Asynchronous reset mid-emit discards the bundle.
      bus_a.hub75_ready = 1'b0;
      rand_bundle();
      drive(0, any);
      tick();
      bus_a.in_valid = 1'b0;
      beat(0, "t4.b0");
      #2 rst_n = 1'b0;
      #1;
      idle(0, "t4.rst", 1'b0);
      sb_a.delete();
      #2 rst_n = 1'b1;
      tick();
      bus_a.hub75_ready = 1'b1;
      idle(0, "t4.rel", 1'b0);
      rand_bundle();
      drive(0, any);
      tick();
      bus_a.in_valid = 1'b0;
      beat(0, "t4.n0");
      tick();
      beat(0, "t4.n1");
      tick();
      idle(0, "t4.done", 1'b1);
      tick();

      // Back-to-back bundles with in_valid held high: period NUM_CHANNELS+1.
      rand_bundle();
      drive(0, any);
      tick();
      for (int i = 0; i < 3; i++) begin
         beat(0, $sformatf("t5.%0d.b0", i));
         if (i < 2) begin
            rand_bundle();
            drive(0, any);
         end else begin
            bus_a.in_valid = 1'b0;
         end
         tick();
         beat(0, $sformatf("t5.%0d.b1", i));
         tick();
         idle(0, $sformatf("t5.%0d.done", i), 1'b1);
         tick();
      end
      idle(0, "t5.end", 1'b0);

      chk("sb_a.left", 576'(sb_a.size()), 576'(0));
      chk("sb_b.left", 576'(sb_b.size()), 576'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
